// File: rtl/character_sprite_renderer_pkg.sv
// Shared constants and helpers for the character sprite renderer.
//   SCR_W/SCR_H   OLED geometry (96x64), pixel_index = y*SCR_W + x
//   TEX_DIM       sprite is TEX_DIM x TEX_DIM texels, texel address = row*TEX_DIM + col
//   TEX_*         texel codes returned by the character texture store
//   texel_to_rgb  palette lookup for a texel code that is known to be covered
package character_sprite_renderer_pkg;

  localparam int SCR_W   = 96;
  localparam int SCR_H   = 64;
  localparam int TEX_DIM = 5;
  localparam int IDX_W   = 13;
  localparam int X_W     = 7;
  localparam int Y_W     = 6;

  localparam logic [3:0] TEX_TRANSPARENT = 4'b0000;
  localparam logic [3:0] TEX_BODY        = 4'b1000;
  localparam logic [3:0] TEX_EYE         = 4'b1111;

  // Transparent texels show the background; every unnamed non-zero code
  // falls back to the misc colour.
  function automatic logic [15:0] texel_to_rgb(input logic [3:0]  code,
                                               input logic [15:0] bg,
                                               input logic [15:0] body,
                                               input logic [15:0] eye,
                                               input logic [15:0] misc);
    logic [15:0] rgb;
    if (code == TEX_TRANSPARENT)  rgb = bg;
    else if (code == TEX_BODY)    rgb = body;
    else if (code == TEX_EYE)     rgb = eye;
    else                          rgb = misc;
    return rgb;
  endfunction

endpackage

// File: rtl/character_sprite_renderer_if.sv
// Bundle between the OLED scan side / texture store and the sprite renderer.
//   pixel_index  scan index, one pixel per clock
//   frame_begin  1-cycle pulse that latches pos_x/pos_y
//   pos_x/pos_y  requested sprite top-left corner
//   bg_color     colour for transparent and uncovered pixels
//   tex_addr     texel address towards the texture store
//   tex_data     texel code, returned one clock after tex_addr
//   sprite_hit   pixel_color of this cycle comes from the sprite
//   pixel_color  RGB565 towards the OLED
//
// Timing contract: this is a free-running stream with no valid/ready pair.
// Every clock edge accepts one pixel_index and retires one pixel_color;
// pixel_color/sprite_hit for an index sampled at edge E appear after edge
// E+3, tex_addr after edge E+1, and the store must answer tex_data after the
// following edge (E+2). bg_color is sampled one edge after its pixel_index.
interface character_sprite_renderer_if;
  logic [12:0] pixel_index;
  logic        frame_begin;
  logic [6:0]  pos_x;
  logic [5:0]  pos_y;
  logic [15:0] bg_color;
  logic [4:0]  tex_addr;
  logic [3:0]  tex_data;
  logic        sprite_hit;
  logic [15:0] pixel_color;

  modport master (
    output pixel_index, frame_begin, pos_x, pos_y, bg_color, tex_data,
    input  tex_addr, sprite_hit, pixel_color
  );

  modport slave (
    input  pixel_index, frame_begin, pos_x, pos_y, bg_color, tex_data,
    output tex_addr, sprite_hit, pixel_color
  );
endinterface

// File: rtl/character_sprite_renderer_pixel_index_decoder.sv
// Pixel index decoder (first pipeline stage of the sprite renderer).
// Registers x = idx % SCR_W, y = idx / SCR_W and an in-range flag; indices
// past the last pixel of the screen are flagged so the next stage misses.
//   clk, rst_n   clock, asynchronous active-low reset
//   pixel_index  raw OLED scan index
//   x_q, y_q     registered coordinates (only meaningful when in_range_q)
//   in_range_q   registered idx < SCR_W*SCR_H
module character_sprite_renderer_pixel_index_decoder
  import character_sprite_renderer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] pixel_index,
  output logic [X_W-1:0]   x_q,
  output logic [Y_W-1:0]   y_q,
  output logic             in_range_q
);

  localparam logic [IDX_W-1:0] W_IDX = IDX_W'(SCR_W);
  localparam logic [IDX_W-1:0] LIMIT = IDX_W'(SCR_W * SCR_H);

  logic [X_W-1:0] x_d;
  logic [Y_W-1:0] y_d;
  logic           in_range_d;

  // Out-of-range indices may truncate y; in_range_d masks them downstream.
  always_comb begin
    in_range_d = (pixel_index < LIMIT);
    x_d        = X_W'(pixel_index % W_IDX);
    y_d        = Y_W'(pixel_index / W_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      in_range_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      in_range_q <= in_range_d;
    end
  end

endmodule

// File: rtl/character_sprite_renderer.sv
// Character sprite renderer: maps the OLED scan index onto a 5x5 character
// sprite at a frame-latched position and converts texel codes to RGB565.
// Pipeline: S0 decode x/y, S1 hit test + tex_addr + bg capture,
// S2 texture store read (registered inside the store), S3 palette.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         slave side of character_sprite_renderer_if
// Parameters: SCALE_LOG2 (0..2) texel size, INIT_X/INIT_Y reset position,
// BODY/EYE/MISC_COLOR palette entries.
module character_sprite_renderer
  import character_sprite_renderer_pkg::*;
#(
  parameter int          SCALE_LOG2 = 0,
  parameter int          INIT_X     = 45,
  parameter int          INIT_Y     = 29,
  parameter logic [15:0] BODY_COLOR = 16'hFFE0,
  parameter logic [15:0] EYE_COLOR  = 16'h0000,
  parameter logic [15:0] MISC_COLOR = 16'hF800
) (
  input  logic                        clk,
  input  logic                        rst_n,
  character_sprite_renderer_if.slave  bus
);

  localparam logic [7:0] SPAN     = 8'(TEX_DIM << SCALE_LOG2);
  localparam logic [7:0] TEX_DIM8 = 8'(TEX_DIM);

  logic [X_W-1:0] x_s0;
  logic [Y_W-1:0] y_s0;
  logic           in_range_s0;

  character_sprite_renderer_pixel_index_decoder u_decoder (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_index (bus.pixel_index),
    .x_q         (x_s0),
    .y_q         (y_s0),
    .in_range_q  (in_range_s0)
  );

  logic [X_W-1:0] lat_x_q, lat_x_d;
  logic [Y_W-1:0] lat_y_q, lat_y_d;
  logic [7:0]     dx, dy, col, row, addr_calc;
  logic           hit1_q, hit1_d;
  logic [4:0]     tex_addr_q, tex_addr_d;
  logic [15:0]    bg1_q, bg2_q;
  logic           hit2_q;
  logic [15:0]    pixel_color_q, pixel_color_d;
  logic           sprite_hit_q, sprite_hit_d;

  always_comb begin
    // The latch is written at the same edge that samples pixel_index, so the
    // pixel arriving with frame_begin is tested against the new position.
    lat_x_d = bus.frame_begin ? bus.pos_x : lat_x_q;
    lat_y_d = bus.frame_begin ? bus.pos_y : lat_y_q;

    // dx/dy use the unwrapped x/y, so a sprite hanging off the right or
    // bottom edge is clipped rather than wrapping onto the next row/column.
    dx = {1'b0, x_s0} - {1'b0, lat_x_q};
    dy = {2'b00, y_s0} - {2'b00, lat_y_q};
    hit1_d = in_range_s0 && (x_s0 >= lat_x_q) && (y_s0 >= lat_y_q) &&
             (dx < SPAN) && (dy < SPAN);

    col       = dx >> SCALE_LOG2;
    row       = dy >> SCALE_LOG2;
    addr_calc = row * TEX_DIM8 + col;
    // Holding the address on a miss keeps the store's bus quiet off-sprite.
    tex_addr_d = hit1_d ? 5'(addr_calc) : tex_addr_q;

    pixel_color_d = hit2_q ? texel_to_rgb(bus.tex_data, bg2_q, BODY_COLOR,
                                          EYE_COLOR, MISC_COLOR)
                           : bg2_q;
    sprite_hit_d  = hit2_q && (bus.tex_data != TEX_TRANSPARENT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_x_q       <= X_W'(INIT_X);
      lat_y_q       <= Y_W'(INIT_Y);
      hit1_q        <= 1'b0;
      tex_addr_q    <= '0;
      bg1_q         <= '0;
      hit2_q        <= 1'b0;
      bg2_q         <= '0;
      pixel_color_q <= '0;
      sprite_hit_q  <= 1'b0;
    end else begin
      lat_x_q       <= lat_x_d;
      lat_y_q       <= lat_y_d;
      hit1_q        <= hit1_d;
      tex_addr_q    <= tex_addr_d;
      bg1_q         <= bus.bg_color;
      // tex_data for this pixel arrives at the next edge; carry hit/bg along.
      hit2_q        <= hit1_q;
      bg2_q         <= bg1_q;
      pixel_color_q <= pixel_color_d;
      sprite_hit_q  <= sprite_hit_d;
    end
  end

  assign bus.tex_addr    = tex_addr_q;
  assign bus.sprite_hit  = sprite_hit_q;
  assign bus.pixel_color = pixel_color_q;

endmodule

// File: tb/tb_character_sprite_renderer.sv
// Bench for character_sprite_renderer: two instances (SCALE_LOG2 = 0 and 1)
// share one stimulus stream; each has a registered texture ROM and its own
// expected queues filled by a geometric reference model.
module tb_character_sprite_renderer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  character_sprite_renderer_if if0();
  character_sprite_renderer_if if1();

  character_sprite_renderer #(.SCALE_LOG2(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  character_sprite_renderer #(.SCALE_LOG2(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Texture store: 1-cycle registered ROM.
  function automatic logic [3:0] rom_code(input int a);
    if (a == 2)  return 4'b1000;
    if (a == 12) return 4'b1111;
    return 4'b0000;
  endfunction

  always @(posedge clk) begin
    if0.tex_data <= rom_code(int'(if0.tex_addr));
    if1.tex_data <= rom_code(int'(if1.tex_addr));
  end

  // ---------------- scoreboard state ----------------
  int tests  = 0;
  int failed = 0;

  logic [36:0] aq0[$], aq1[$];   // {due cycle, tex_addr}
  logic [48:0] cq0[$], cq1[$];   // {due cycle, sprite_hit, pixel_color}

  int          m_lx, m_ly;
  int          m_addr[2];
  bit          pend_v;
  int          pend_due;
  bit          pend_hit[2];
  logic [3:0]  pend_code[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Sprite covers [lx, lx+5*2^s) x [ly, ly+5*2^s) on the visible screen only.
  function automatic void geo(input int idx, input int s, output bit hit, output int addr);
    int x, y, span;
    hit  = 0;
    addr = 0;
    if (idx >= 96 * 64) return;
    x    = idx % 96;
    y    = idx / 96;
    span = 5 * (1 << s);
    if (x >= m_lx && y >= m_ly && x - m_lx < span && y - m_ly < span) begin
      hit  = 1;
      addr = ((y - m_ly) / (1 << s)) * 5 + (x - m_lx) / (1 << s);
    end
  endfunction

  function automatic logic [15:0] palette(input logic [3:0] code, input logic [15:0] bg);
    if (code == 4'h0) return bg;
    if (code == 4'h8) return 16'hFFE0;
    if (code == 4'hF) return 16'h0000;
    return 16'hF800;
  endfunction

  // ---------------- driver ----------------
  // One call = one pixel. bg_color of this call belongs to the previous pixel,
  // since the renderer samples it one edge after pixel_index.
  task automatic drive(input int idx, input bit fb, input int px, input int py,
                       input logic [15:0] bg);
    bit h;
    int a, due;
    logic [15:0] col;
    if0.pixel_index = 13'(idx); if1.pixel_index = 13'(idx);
    if0.frame_begin = fb;       if1.frame_begin = fb;
    if0.pos_x = 7'(px);         if1.pos_x = 7'(px);
    if0.pos_y = 6'(py);         if1.pos_y = 6'(py);
    if0.bg_color = bg;          if1.bg_color = bg;
    if (pend_v) begin
      for (int s = 0; s < 2; s++) begin
        col = pend_hit[s] ? palette(pend_code[s], bg) : bg;
        if (s == 0) cq0.push_back({32'(pend_due), pend_hit[s] && pend_code[s] != 4'h0, col});
        else        cq1.push_back({32'(pend_due), pend_hit[s] && pend_code[s] != 4'h0, col});
      end
    end
    if (fb) begin
      m_lx = px;
      m_ly = py;
    end
    due = cyc + 1;
    for (int s = 0; s < 2; s++) begin
      geo(idx, s, h, a);
      if (h) m_addr[s] = a;
      if (s == 0) aq0.push_back({32'(due + 1), 5'(m_addr[s])});
      else        aq1.push_back({32'(due + 1), 5'(m_addr[s])});
      pend_hit[s]  = h;
      pend_code[s] = h ? rom_code(a) : 4'h0;
    end
    pend_v   = 1;
    pend_due = due + 3;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_color0", 32'(if0.pixel_color), 32'h0);
    check("rst_hit0",   32'(if0.sprite_hit),  32'h0);
    check("rst_addr0",  32'(if0.tex_addr),    32'h0);
    check("rst_color1", 32'(if1.pixel_color), 32'h0);
    check("rst_hit1",   32'(if1.sprite_hit),  32'h0);
    aq0.delete(); aq1.delete(); cq0.delete(); cq1.delete();
    pend_v = 0;
    m_lx = 45; m_ly = 29;
    m_addr[0] = 0; m_addr[1] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [36:0] ea;
  logic [48:0] ec;
  always @(negedge clk) begin
    if (aq0.size() > 0 && int'(aq0[0][36:5]) == cyc) begin
      ea = aq0.pop_front();
      check("tex_addr_s0", 32'(if0.tex_addr), 32'(ea[4:0]));
    end
    if (aq1.size() > 0 && int'(aq1[0][36:5]) == cyc) begin
      ea = aq1.pop_front();
      check("tex_addr_s1", 32'(if1.tex_addr), 32'(ea[4:0]));
    end
    if (cq0.size() > 0 && int'(cq0[0][48:17]) == cyc) begin
      ec = cq0.pop_front();
      check("pixel_s0", {15'h0, if0.sprite_hit, if0.pixel_color}, {15'h0, ec[16:0]});
    end
    if (cq1.size() > 0 && int'(cq1[0][48:17]) == cyc) begin
      ec = cq1.pop_front();
      check("pixel_s1", {15'h0, if1.sprite_hit, if1.pixel_color}, {15'h0, ec[16:0]});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int idx, lx, ly, x, y, px, py;
    bit fb;
    rst_n = 1'b1;
    pend_v = 0;
    m_lx = 45; m_ly = 29;
    m_addr[0] = 0; m_addr[1] = 0;
    drive(0, 0, 0, 0, 16'h0);
    do_reset();

    // T1: traffic, reset mid-stream, then a body texel at the reset position
    for (int i = 0; i < 20; i++) drive($urandom_range(0, 6143), 0, 0, 0, 16'($urandom));
    do_reset();
    drive(29 * 96 + 47, 0, 0, 0, 16'h1234);
    drive(0, 0, 0, 0, 16'h1234);

    // T2: new position latched with the pixel itself, eye texel
    drive(12 * 96 + 12, 1, 10, 10, 16'h0F0F);
    // T3: transparent texel and an uncovered pixel
    drive(10 * 96 + 10, 0, 10, 10, 16'h0F0F);
    drive(0, 0, 10, 10, 16'h5555);
    drive(11 * 96 + 10, 0, 10, 10, 16'hAAAA);

    // T4: clipped sprite at the bottom-right corner, full frame plus one
    drive(0, 1, 94, 62, 16'h0001);
    for (int i = 1; i < 6144; i++) drive(i, 0, 94, 62, 16'($urandom_range(0, 3)));
    drive(6144, 0, 94, 62, 16'h7777);
    drive(8191, 0, 94, 62, 16'h7777);

    // T5: pos change without frame_begin must not move the sprite
    drive(20 * 96 + 22, 1, 20, 20, 16'h0101);
    drive(20 * 96 + 22, 0, 40, 20, 16'h0202);
    drive(20 * 96 + 42, 0, 40, 20, 16'h0303);
    drive(20 * 96 + 42, 1, 40, 20, 16'h0404);
    drive(20 * 96 + 22, 0, 40, 20, 16'h0505);

    // T6: origin position, texel scaling seen on the SCALE_LOG2=1 instance
    drive(0, 1, 0, 0, 16'h0606);
    drive(5 * 96 + 5, 0, 0, 0, 16'h0707);
    drive(9 * 96 + 9, 0, 0, 0, 16'h0808);
    drive(10 * 96 + 10, 0, 0, 0, 16'h0909);
    drive(2, 0, 0, 0, 16'h0A0A);

    // Random traffic, half of it aimed around the sprite
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      fb = ($urandom_range(0, 39) == 0);
      px = $urandom_range(0, 127);
      py = $urandom_range(0, 63);
      lx = fb ? px : m_lx;
      ly = fb ? py : m_ly;
      if ($urandom_range(0, 1) == 1) begin
        x = lx + int'($urandom_range(0, 12)) - 1;
        y = ly + int'($urandom_range(0, 12)) - 1;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        idx = y * 96 + x;
        if (idx > 8191) idx = 8191;
      end else begin
        idx = $urandom_range(0, 8191);
      end
      drive(idx, fb, px, py, 16'($urandom));
    end

    // Drain
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 16'h0);
    repeat (6) @(negedge clk);
    check("drain_queues", 32'(aq0.size() + aq1.size() + cq0.size() + cq1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
